ws_sta_tile_sequencer: RTL

//  Sequences one dimension_aligned_ws_sta_16x16x1x4x1 weight-stationary array per tile command.

---
 rtl/ws_sta_tile_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ws_sta_tile_sequencer.sv
// Tile command sequencer for a weight-stationary systolic array: optional weight preload,
// activation streaming, and valid/last tagging of the result beats as they leave the array.
module ws_sta_tile_sequencer #(
  parameter int ROWS     = 16,
  parameter int A_LANES  = 16,
  parameter int B_LANES  = 64,
  parameter int C_LANES  = 64,
  parameter int PIPE_LAT = 18,
  parameter int LEN_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_reload_b,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [B_LANES*8-1:0]  b_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [A_LANES*8-1:0]  a_data,
  output logic [A_LANES*8-1:0]  arr_input_a,
  output logic [B_LANES*8-1:0]  arr_input_b,
  output logic [ROWS-1:0]       arr_propagate_b,
  input  logic [C_LANES*20-1:0] arr_output_c,
  output logic                  c_valid,
  output logic                  c_last,
  output logic [C_LANES*20-1:0] c_data,
  output logic                  busy,
  output logic                  done
);

  localparam int ROW_W = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seqStateT;

  seqStateT             state;
  seqStateT             stateNext;
  logic [LEN_W-1:0]     lenReg;
  logic [ROW_W-1:0]     rowCnt;
  logic [LEN_W-1:0]     beatCnt;
  logic [PIPE_LAT-1:0]  dlValid;
  logic [PIPE_LAT-1:0]  dlLast;

  logic aFire;
  logic bFire;
  logic lastRow;
  logic lastBeat;
  logic enterStream;

  // Handshake readies are pure state decodes so the DMA sees them without extra latency.
  assign cmd_ready = (state == IDLE);
  assign b_ready   = (state == LOAD_B);
  assign a_ready   = (state == STREAM);
  assign busy      = (state != IDLE);

  assign aFire    = a_valid && a_ready;
  assign bFire    = b_valid && b_ready;
  assign lastRow  = (rowCnt == ROW_W'(ROWS - 1));
  assign lastBeat = (beatCnt == (lenReg - LEN_W'(1)));

  assign enterStream = (state != STREAM) && (stateNext == STREAM);

  // Results come straight from the array; only their valid/last qualifiers are delayed.
  assign c_data  = arr_output_c;
  assign c_valid = dlValid[PIPE_LAT-1];
  assign c_last  = dlLast[PIPE_LAT-1];

  // NOTE: every signal written in an always_comb gets a default at the top of the block;
  // a path that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_reload_b)          stateNext = LOAD_B;
          else if (cmd_len != '0)    stateNext = STREAM;
          else                       stateNext = DONE;
        end
      end
      LOAD_B: begin
        if (bFire && lastRow) stateNext = (lenReg != '0) ? STREAM : DONE;
      end
      STREAM: begin
        if (aFire && lastBeat) stateNext = DRAIN;
      end
      DRAIN: begin
        // Empty delay line means the tile's c_last has already been presented.
        if (dlValid == '0) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      lenReg          <= '0;
      rowCnt          <= '0;
      beatCnt         <= '0;
      arr_input_a     <= '0;
      arr_input_b     <= '0;
      arr_propagate_b <= '0;
      done            <= 1'b0;
    end else begin
      state <= stateNext;

      if (cmd_valid && cmd_ready) lenReg <= cmd_len;

      if (state == IDLE)  rowCnt <= '0;
      else if (bFire)     rowCnt <= rowCnt + ROW_W'(1);

      if (enterStream)    beatCnt <= '0;
      else if (aFire)     beatCnt <= beatCnt + LEN_W'(1);

      // Weights hold between beats; propagate only pulses on an accepted weight vector.
      if (bFire) arr_input_b <= b_data;
      arr_propagate_b <= bFire ? '1 : '0;

      // Bubbles present zeros so the array never sees a stale activation.
      arr_input_a <= aFire ? a_data : '0;

      done <= (stateNext == DONE);
    end
  end

  // NOTE: the delay line is a shift register, not a RAM, and it is reset because its valid
  // bits directly drive c_valid; leaving it unreset would replay dropped beats after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      dlValid <= '0;
      dlLast  <= '0;
    end else begin
      dlValid[0] <= aFire;
      dlLast[0]  <= aFire && lastBeat;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dlValid[i] <= dlValid[i-1];
        dlLast[i]  <= dlLast[i-1];
      end
    end
  end

  // Results may only leave the array while a tile is streaming or draining.
  cValidInWindow: assert property (@(posedge clock) disable iff (reset)
    c_valid |-> (state == STREAM || state == DRAIN));

  readyExclusive: assert property (@(posedge clock) disable iff (reset)
    $onehot0({cmd_ready, a_ready, b_ready}));

endmodule
